rf_wb_stage: RTL and testbench

- Writeback stage directly upstream of the RV32IC register file.
- Merges results from the single-cycle ALU and the load/store unit (LSU) into the register file's single write port (we/write_addr/din).
- Buffers colliding results in a small in-order FIFO.
- Sign- or zero-extends load data and suppresses writes to x0.

---
 rtl/rf_wb_pkg.sv | 35 +++
 rtl/rf_wb_stage_fifo.sv | 64 ++++++
 rtl/rf_wb_stage.sv | 175 +++++++++++++++++
 tb/tb_rf_wb_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and load-extension helper for the RV32 writeback stage.
// Optional forwarding is enabled by defining WB_FWD_EN.
package rf_wb_pkg;

  localparam int unsigned WB_XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  // Illegal funct3 encodings fall through to the full-word case.
  function automatic logic [WB_XLEN-1:0] load_extend(input logic [WB_XLEN-1:0] data,
                                                     input logic [2:0]         funct3,
                                                     input logic [1:0]         off);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (funct3)
      LB:      return {{(WB_XLEN-8){b[7]}}, b};
      LH:      return {{(WB_XLEN-16){h[15]}}, h};
      LBU:     return {{(WB_XLEN-8){1'b0}}, b};
      LHU:     return {{(WB_XLEN-16){1'b0}}, h};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/rf_wb_stage_fifo.sv
// In-order circular buffer of pending writeback results: 0-2 pushes, 0-1 pop per cycle.
// With WB_FWD_EN defined the storage and read pointer are exposed for forwarding.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push0,
  input  wb_entry_t         push0_data,
  input  logic              push1,
  input  wb_entry_t         push1_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output wb_entry_t         head
`ifdef WB_FWD_EN
  ,
  output logic [PW-1:0]     rd_ptr,
  output wb_entry_t         entries [DEPTH]
`endif
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, wr_second, rd_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d      = wr_q;
    wr_second = push0 ? ptr_inc(wr_q) : wr_q;
    if (push0) wr_d = ptr_inc(wr_d);
    if (push1) wr_d = ptr_inc(wr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push0) mem_q[wr_q] <= push0_data;
      if (push1) mem_q[wr_second] <= push1_data;
      wr_q    <= wr_d;
      rd_q    <= pop ? ptr_inc(rd_q) : rd_q;
      count_q <= count_q - CW'(pop) + CW'(push0) + CW'(push1);
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

`ifdef WB_FWD_EN
  assign rd_ptr  = rd_q;
  assign entries = mem_q;
`endif

endmodule

// File: rtl/rf_wb_stage.sv
// Writeback stage: merges ALU and load results onto the single register-file write port.
// Define WB_FWD_EN to add the two combinational forwarding read ports.
module rf_wb_stage
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_off,
  output logic            we,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] din
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]      rs_addr0,
  input  logic [4:0]      rs_addr1,
  output logic            fwd_hit0,
  output logic            fwd_hit1,
  output logic [XLEN-1:0] fwd_data0,
  output logic [XLEN-1:0] fwd_data1
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  wb_entry_t       head, lsu_ent, alu_ent, push0_data, push1_data, sel;
  logic            push0, push1, pop, sel_valid, lsu_cand, alu_cand;
  logic            we_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] din_q;

  // Two free slots guarantee that any pair of same-cycle acceptances fits.
  assign alu_ready = (count <= CW'(DEPTH - 2));
  assign lsu_ready = alu_ready;

  // rd==0 results are handshaken but dropped here.
  assign lsu_cand = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign alu_cand = alu_valid && alu_ready && (alu_rd != 5'd0);

  assign lsu_ent = '{rd: lsu_rd, data: load_extend(lsu_data, lsu_funct3, lsu_off)};
  assign alu_ent = '{rd: alu_rd, data: alu_data};

  // Priority FIFO head > LSU > ALU; leftovers go to the tail in the same order.
  always_comb begin
    sel        = lsu_ent;
    sel_valid  = 1'b0;
    pop        = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    push0_data = lsu_ent;
    push1_data = alu_ent;
    if (count != '0) begin
      sel       = head;
      sel_valid = 1'b1;
      pop       = 1'b1;
      if (lsu_cand) begin
        push0 = 1'b1;
        push1 = alu_cand;
      end else if (alu_cand) begin
        push0      = 1'b1;
        push0_data = alu_ent;
      end
    end else if (lsu_cand) begin
      sel        = lsu_ent;
      sel_valid  = 1'b1;
      push0      = alu_cand;
      push0_data = alu_ent;
    end else if (alu_cand) begin
      sel       = alu_ent;
      sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q <= sel_valid;
      if (sel_valid) begin
        addr_q <= sel.rd;
        din_q  <= sel.data;
      end
    end
  end

  assign we         = we_q;
  assign write_addr = addr_q;
  assign din        = din_q;

`ifdef WB_FWD_EN
  logic [PW-1:0] rd_ptr;
  wb_entry_t     entries [DEPTH];
  logic [4:0]    rs   [2];
  logic          hit  [2];
  logic [XLEN-1:0] fdata [2];
  logic [PW:0]   idx;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0     (push0),
    .push0_data(push0_data),
    .push1     (push1),
    .push1_data(push1_data),
    .pop       (pop),
    .count     (count),
    .head      (head),
    .rd_ptr    (rd_ptr),
    .entries   (entries)
  );

  assign rs[0] = rs_addr0;
  assign rs[1] = rs_addr1;

  // Walk oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    idx = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      hit[j]   = 1'b0;
      fdata[j] = '0;
      if (rs[j] != 5'd0) begin
        if (we_q && (addr_q == rs[j])) begin
          hit[j]   = 1'b1;
          fdata[j] = din_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          idx = {1'b0, rd_ptr} + (PW + 1)'(i);
          if (idx >= (PW + 1)'(DEPTH)) idx = idx - (PW + 1)'(DEPTH);
          if ((CW'(i) < count) && (entries[idx[PW-1:0]].rd == rs[j])) begin
            hit[j]   = 1'b1;
            fdata[j] = entries[idx[PW-1:0]].data;
          end
        end
      end
    end
  end

  assign fwd_hit0  = hit[0];
  assign fwd_hit1  = hit[1];
  assign fwd_data0 = fdata[0];
  assign fwd_data1 = fdata[1];
`else
  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0     (push0),
    .push0_data(push0_data),
    .push1     (push1),
    .push1_data(push1_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );
`endif

endmodule

// File: tb/tb_rf_wb_stage.sv
// Self-checking bench for rf_wb_stage: directed vector table plus multi-cycle sequences.
// The forwarding sequence is compiled only when WB_FWD_EN is defined.
module tb_rf_wb_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, write_addr;
  logic [31:0] alu_data, lsu_data, din;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_off;
  logic        we;
`ifdef WB_FWD_EN
  logic [4:0]  rs_addr0, rs_addr1;
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_stage #(
    .DEPTH(DEPTH),
    .XLEN (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_funct3(lsu_funct3),
    .lsu_off   (lsu_off),
    .we        (we),
    .write_addr(write_addr),
    .din       (din)
`ifdef WB_FWD_EN
    ,
    .rs_addr0  (rs_addr0),
    .rs_addr1  (rs_addr1),
    .fwd_hit0  (fwd_hit0),
    .fwd_hit1  (fwd_hit1),
    .fwd_data0 (fwd_data0),
    .fwd_data1 (fwd_data1)
`endif
  );

  typedef struct {
    string       name;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vq[$];
  logic [36:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    lsu_valid  = 1'b0;
    alu_rd     = '0;
    lsu_rd     = '0;
    alu_data   = '0;
    lsu_data   = '0;
    lsu_funct3 = 3'b010;
    lsu_off    = '0;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3,
                           input logic [1:0] off);
    lsu_valid  = 1'b1;
    lsu_rd     = rd;
    lsu_data   = d;
    lsu_funct3 = f3;
    lsu_off    = off;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    alu_valid  = v.alu_v;
    alu_rd     = v.alu_rd;
    alu_data   = v.alu_d;
    lsu_valid  = v.lsu_v;
    lsu_rd     = v.lsu_rd;
    lsu_data   = v.lsu_d;
    lsu_funct3 = v.f3;
    lsu_off    = v.off;
    step();
    idle_inputs();
    check({v.name, "_we"}, 32'(we), 32'(v.exp_we));
    if (v.exp_we) begin
      check({v.name, "_addr"}, 32'(write_addr), 32'(v.exp_addr));
      check({v.name, "_din"}, din, v.exp_din);
    end
    step();
    check({v.name, "_idle_we"}, 32'(we), 32'd0);
    check({v.name, "_ready"}, {30'd0, alu_ready, lsu_ready}, 32'd3);
  endtask

  initial begin
    int li, ai, written;
    logic saw_stall;
    logic [36:0] exp_e;

    idle_inputs();
`ifdef WB_FWD_EN
    rs_addr0 = '0;
    rs_addr1 = '0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(write_addr), 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);
    @(negedge clk) rst_n = 1'b1;
    step();

    // name, alu_v, alu_rd, alu_d, lsu_v, lsu_rd, lsu_d, f3, off, exp_we, exp_addr, exp_din
    vq.push_back('{"alu_x5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 3'b000, 0, 1, 5, 32'hDEADBEEF});
    vq.push_back('{"lb_off2", 0, 0, 0, 1, 3, 32'h00800000, 3'b000, 2, 1, 3, 32'hFFFFFF80});
    vq.push_back('{"lb_off0", 0, 0, 0, 1, 6, 32'hABCD1234, 3'b000, 0, 1, 6, 32'h00000034});
    vq.push_back('{"lb_off3", 0, 0, 0, 1, 7, 32'hABCD1234, 3'b000, 3, 1, 7, 32'hFFFFFFAB});
    vq.push_back('{"lbu_off3", 0, 0, 0, 1, 8, 32'hABCD1234, 3'b100, 3, 1, 8, 32'h000000AB});
    vq.push_back('{"lhu_off2", 0, 0, 0, 1, 9, 32'hABCD1234, 3'b101, 2, 1, 9, 32'h0000ABCD});
    vq.push_back('{"lh_off2", 0, 0, 0, 1, 10, 32'hABCD1234, 3'b001, 2, 1, 10, 32'hFFFFABCD});
    vq.push_back('{"lh_off1", 0, 0, 0, 1, 11, 32'hABCD1234, 3'b001, 1, 1, 11, 32'h00001234});
    vq.push_back('{"lh_off0", 0, 0, 0, 1, 12, 32'h8000F0F0, 3'b001, 0, 1, 12, 32'hFFFFF0F0});
    vq.push_back('{"lhu_off0", 0, 0, 0, 1, 13, 32'h8000F0F0, 3'b101, 0, 1, 13, 32'h0000F0F0});
    vq.push_back('{"lw_off3", 0, 0, 0, 1, 14, 32'hABCD1234, 3'b010, 3, 1, 14, 32'hABCD1234});
    vq.push_back('{"ill_011", 0, 0, 0, 1, 15, 32'h80818283, 3'b011, 1, 1, 15, 32'h80818283});
    vq.push_back('{"ill_110", 0, 0, 0, 1, 16, 32'h80818283, 3'b110, 2, 1, 16, 32'h80818283});
    vq.push_back('{"ill_111", 0, 0, 0, 1, 17, 32'h80818283, 3'b111, 3, 1, 17, 32'h80818283});
    vq.push_back('{"alu_x0", 1, 0, 32'h12345678, 0, 0, 0, 3'b000, 0, 0, 0, 0});
    vq.push_back('{"lsu_x0", 0, 0, 0, 1, 0, 32'h12345678, 3'b010, 0, 0, 0, 0});
    vq.push_back('{"x0_alu_x31", 1, 31, 32'h0BADF00D, 1, 0, 32'h1, 3'b010, 0, 1, 31, 32'h0BADF00D});
    foreach (vq[i]) run_vec(vq[i]);

    // Same-cycle LSU and ALU: LSU written first.
    drive_lsu(5'd3, 32'h00800000, 3'b000, 2'd2);
    drive_alu(5'd4, 32'h00000001);
    step();
    idle_inputs();
    check("pair_first", {we, write_addr, din}, {1'b1, 5'd3, 32'hFFFFFF80});
    step();
    check("pair_second", {we, write_addr, din}, {1'b1, 5'd4, 32'h00000001});
    step();
    check("pair_idle_we", 32'(we), 32'd0);

    // Both sources valid every cycle; scoreboard holds accepted-but-unwritten results.
    li = 0;
    ai = 0;
    written = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 200 && written < 24; cyc++) begin
      lsu_valid = (li < 12);
      if (li < 12) drive_lsu(5'(li + 1), 32'h10000000 + 32'(li), 3'b010, 2'd0);
      alu_valid = (ai < 12);
      if (ai < 12) drive_alu(5'(ai + 16), 32'h20000000 + 32'(ai));
      if (lsu_valid && lsu_ready) begin
        sb.push_back({lsu_rd, lsu_data});
        li++;
      end
      if (alu_valid && alu_ready) begin
        sb.push_back({alu_rd, alu_data});
        ai++;
      end
      step();
      check("stress_we", 32'(we), 32'(sb.size() != 0));
      if (we && sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("stress_order", {27'd0, write_addr}, {27'd0, exp_e[36:32]});
        check("stress_din", din, exp_e[31:0]);
        written++;
      end
      check("stress_ready", 32'(alu_ready), 32'(sb.size() <= DEPTH - 2));
      if (!alu_ready) saw_stall = 1'b1;
    end
    idle_inputs();
    check("stress_written", 32'(written), 32'd24);
    check("stress_stalled", 32'(saw_stall), 32'd1);
    step();
    check("stress_drain_we", 32'(we), 32'd0);

    // Build three pending FIFO entries, then reset mid-operation.
    for (int k = 0; k < 3; k++) begin
      drive_lsu(5'(20 + k), 32'hAAAA0000 + 32'(k), 3'b010, 2'd0);
      drive_alu(5'(24 + k), 32'hBBBB0000 + 32'(k));
      step();
    end
    idle_inputs();
    check("prerst_we", 32'(we), 32'd1);
    check("prerst_ready", {30'd0, alu_ready, lsu_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_addr_din", {27'd0, write_addr} | din, 32'd0);
    check("midrst_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check("postrst_we", 32'(we), 32'd0);
      step();
    end
    check("postrst_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);

`ifdef WB_FWD_EN
    // Output reg gets x10 while the FIFO holds x7=0x11 (older) then x7=0x22.
    drive_lsu(5'd9, 32'h99, 3'b010, 2'd0);
    drive_alu(5'd10, 32'h1010);
    step();
    drive_lsu(5'd7, 32'h11, 3'b010, 2'd0);
    drive_alu(5'd7, 32'h22);
    step();
    idle_inputs();
    rs_addr0 = 5'd7;
    rs_addr1 = 5'd0;
    #1;
    check("fwd_hit0", 32'(fwd_hit0), 32'd1);
    check("fwd_data0", fwd_data0, 32'h22);
    check("fwd_x0_hit", 32'(fwd_hit1), 32'd0);
    check("fwd_x0_data", fwd_data1, 32'd0);
    rs_addr1 = 5'd10;
    #1;
    check("fwd_outreg", {31'd0, fwd_hit1} ^ fwd_data1, 32'h1011);
    rs_addr1 = 5'd9;
    #1;
    check("fwd_miss", 32'(fwd_hit1), 32'd0);
    rs_addr0 = '0;
    rs_addr1 = '0;
    repeat (4) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
